// File: rtl/xosera_bus_sync_if.sv
// Host-bus signal bundle between the m68k pin side / core side and xosera_bus_sync.
// slave = the sync block itself, master = whatever drives the pins and consumes strobes.
interface xosera_bus_sync_if #(
  parameter int DATA_W   = 8,
  parameter int REGNUM_W = 4
);
  logic                bus_cs_n_i;
  logic                bus_rd_nwr_i;
  logic                bus_bytesel_i;
  logic [REGNUM_W-1:0] bus_reg_num_i;
  logic [DATA_W-1:0]   bus_data_i;
  logic [DATA_W-1:0]   bus_data_o;
  logic                bus_out_ena_o;
  logic                bus_irq_n_o;
  logic                irq_i;
  logic                wr_strobe_o;
  logic                rd_strobe_o;
  logic [REGNUM_W-1:0] reg_num_o;
  logic                bytesel_o;
  logic [DATA_W-1:0]   wr_data_o;
  logic [DATA_W-1:0]   rd_data_i;
  logic                timeout_o;

  modport slave (
    input  bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i, bus_data_i, irq_i, rd_data_i,
    output bus_data_o, bus_out_ena_o, bus_irq_n_o, wr_strobe_o, rd_strobe_o,
           reg_num_o, bytesel_o, wr_data_o, timeout_o
  );

  modport master (
    output bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i, bus_data_i, irq_i, rd_data_i,
    input  bus_data_o, bus_out_ena_o, bus_irq_n_o, wr_strobe_o, rd_strobe_o,
           reg_num_o, bytesel_o, wr_data_o, timeout_o
  );
endinterface

// File: rtl/xosera_bus_sync.sv
// m68k bus front end: synchronises CS/RnW into clk, issues one strobe per CS assertion.
// Optional macro XOSERA_BUS_TIMEOUT_EN forces release of a CS held longer than TIMEOUT_CYC.
module xosera_bus_sync #(
  parameter int DATA_W      = 8,
  parameter int REGNUM_W    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  xosera_bus_sync_if.slave        bif
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("xosera_bus_sync: SYNC_STAGES must be 2..4 and TIMEOUT_CYC >= 1");
  end

  typedef struct packed {
    logic [REGNUM_W-1:0] reg_num;
    logic                bytesel;
    logic [DATA_W-1:0]   data;
  } bus_req_t;

  typedef enum logic [1:0] {IDLE, RD_FETCH, WAIT_RELEASE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, rnw_sync;
  logic                   cs_s, rnw_s;
  bus_req_t               pin_q, cap_q;
  state_t                 state, state_nx;
  logic                   wr_stb_q, rd_stb_q, wr_stb_nx, rd_stb_nx;
  logic                   cap_en, fetch_en, cnt_clr, tmo_nx;
  logic [DATA_W-1:0]      rd_q;
  logic                   irq_n_q;

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign rnw_s = rnw_sync[SYNC_STAGES-1];

  // Pin drivers follow the raw pins so the bus sees data as soon as the host asks.
  assign bif.bus_out_ena_o = ~bif.bus_cs_n_i & bif.bus_rd_nwr_i;

  // Address/data get a single register: they settle long before cs_s can assert.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cs_sync  <= '1;
      rnw_sync <= '1;
      pin_q    <= '0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bif.bus_cs_n_i};
      rnw_sync <= {rnw_sync[SYNC_STAGES-2:0], bif.bus_rd_nwr_i};
      pin_q    <= {bif.bus_reg_num_i, bif.bus_bytesel_i, bif.bus_data_i};
    end
  end

`ifdef XOSERA_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt;
  logic             tmo_q;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i)                cnt <= '0;
    else if (cnt_clr)              cnt <= '0;
    else if (state == WAIT_RELEASE) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) tmo_q <= 1'b0;
    else            tmo_q <= tmo_nx;
  end
  assign bif.timeout_o = tmo_q;
`else
  assign bif.timeout_o = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    wr_stb_nx = 1'b0;
    rd_stb_nx = 1'b0;
    cap_en    = 1'b0;
    fetch_en  = 1'b0;
    cnt_clr   = 1'b0;
    tmo_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_s) begin
          cap_en = 1'b1;
          if (rnw_s) begin
            rd_stb_nx = 1'b1;
            state_nx  = RD_FETCH;
          end else begin
            wr_stb_nx = 1'b1;
            cnt_clr   = 1'b1;
            state_nx  = WAIT_RELEASE;
          end
        end
      end
      RD_FETCH: begin
        fetch_en = 1'b1;
        cnt_clr  = 1'b1;
        state_nx = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (cs_s) state_nx = IDLE;
`ifdef XOSERA_BUS_TIMEOUT_EN
        // A stuck CS is released and, if still low, taken as a fresh access.
        else if (cnt == CNT_MAX) begin
          state_nx = IDLE;
          tmo_nx   = 1'b1;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= IDLE;
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      cap_q    <= '0;
      rd_q     <= '0;
      irq_n_q  <= 1'b1;
    end else begin
      state    <= state_nx;
      wr_stb_q <= wr_stb_nx;
      rd_stb_q <= rd_stb_nx;
      if (cap_en)   cap_q <= pin_q;
      if (fetch_en) rd_q  <= bif.rd_data_i;
      irq_n_q  <= ~bif.irq_i;
    end
  end

  assign bif.wr_strobe_o = wr_stb_q;
  assign bif.rd_strobe_o = rd_stb_q;
  assign bif.reg_num_o   = cap_q.reg_num;
  assign bif.bytesel_o   = cap_q.bytesel;
  assign bif.wr_data_o   = cap_q.data;
  assign bif.bus_data_o  = rd_q;
  assign bif.bus_irq_n_o = irq_n_q;

endmodule

// File: doc/xosera_bus_sync.md
Name: xosera_bus_sync

Overview:
Parametrised host-bus front end for Xosera board tops. It sits between the raw asynchronous m68k bus pins and xosera_main. It synchronises bus control into the pixel clock domain and detects access edges. It issues single-cycle read/write strobes, holds registered read data for the pin drivers, and registers the interrupt output.

Parameters:
DATA_W, 8, bus data width (8 or 16)
REGNUM_W, 4, register-number width
SYNC_STAGES, 2, synchroniser depth for bus_cs_n_i/bus_rd_nwr_i (legal 2..4)
TIMEOUT_CYC, 1023, max cycles in WAIT_RELEASE before forced release (used only with the optional feature)

Ports:
clk  in  1  pixel clock (single clock domain)
reset_n_i  in  1  asynchronous active-low reset
bus_cs_n_i  in  1  raw chip select, active low, asynchronous
bus_rd_nwr_i  in  1  raw read(1)/write(0), asynchronous
bus_bytesel_i  in  1  raw byte select
bus_reg_num_i  in  REGNUM_W  raw register number
bus_data_i  in  DATA_W  raw bus data from pin input buffers
bus_data_o  out  DATA_W  registered read data to pin drivers
bus_out_ena_o  out  1  pin output enable
bus_irq_n_o  out  1  registered interrupt, active low
irq_i  in  1  interrupt request from core, active high
wr_strobe_o  out  1  one-cycle write pulse to core
rd_strobe_o  out  1  one-cycle read pulse to core
reg_num_o  out  REGNUM_W  captured register number
bytesel_o  out  1  captured byte select
wr_data_o  out  DATA_W  captured write data
rd_data_i  in  DATA_W  core read data, valid the cycle after rd_strobe_o
timeout_o  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (async assert, sync release): all synchroniser flops for cs_n and rd_nwr reset to 1. FSM in IDLE. wr_strobe_o=0, rd_strobe_o=0, timeout_o=0. reg_num_o=0, bytesel_o=0, wr_data_o=0, bus_data_o=0, bus_irq_n_o=1.
- bus_out_ena_o is combinational from the raw pins: (bus_cs_n_i==0 && bus_rd_nwr_i==1). It is never gated by reset state or the FSM.
- Sync: cs_s and rnw_s are the last stage of SYNC_STAGES flops each. bus_reg_num_i, bus_bytesel_i and bus_data_i are registered once, with no synchroniser. They are sampled only when cs_s asserts, by which time they have been stable ≥SYNC_STAGES cycles.
- FSM IDLE: when cs_s==0, capture reg_num, bytesel and data registers into outputs in the same cycle.
  - If rnw_s==1, pulse rd_strobe_o for 1 cycle and go to RD_FETCH.
  - Otherwise pulse wr_strobe_o for 1 cycle and go to WAIT_RELEASE.
  - Strobe latency: SYNC_STAGES+1 clocks from the raw cs_n falling edge.
- FSM RD_FETCH: load bus_data_o <= rd_data_i, then go to WAIT_RELEASE.
- FSM WAIT_RELEASE: stay until cs_s==1, then go to IDLE. No further strobes are issued, so a held CS produces exactly one access.
- bus_data_o holds its value until the next read fetch.
- CS pulse narrower than SYNC_STAGES clocks: it may be missed. If it is caught, it is treated as a normal access.
- CS re-asserted the cycle after cs_s deasserts: a new access starts from IDLE normally.
- rd_nwr changing mid-access: ignored; direction is latched at the IDLE→access transition.
- Reset during RD_FETCH or WAIT_RELEASE: go to IDLE immediately, with no strobe on the reset-release cycle. If CS is still low at release, the access is taken as new once cs_s sees it low.
- bus_irq_n_o <= ~irq_i every clock (1-cycle latency).
- DATA_W=16: bytesel is still captured and passed through; no byte steering is done here.

Optional Feature:
XOSERA_BUS_TIMEOUT_EN
- Defined: a counter (width clog2(TIMEOUT_CYC+1)) clears on entry to WAIT_RELEASE and increments each cycle there. When it reaches TIMEOUT_CYC, the FSM goes to IDLE and timeout_o pulses for 1 cycle. A CS still held low is then seen as a new access.
- Not defined: no counter; timeout_o tied 0; WAIT_RELEASE waits indefinitely.

Test Plan:
- Write: SYNC_STAGES=2, reg_num=4'h5, data=8'hA7, bytesel=1, CS low 8 clocks → exactly one wr_strobe_o, 3 clocks after the cs_n fall. reg_num_o=5, wr_data_o=A7, bytesel_o=1, bus_out_ena_o=0 throughout.
- Read: reg_num=4'h2, rd_data_i=8'h3C → one rd_strobe_o. bus_data_o=3C one clock after the strobe. bus_out_ena_o=1 exactly while the raw CS is low and rnw=1.
- Back-to-back: write 8'h11 then read, with a 3-clock CS-high gap → wr_strobe_o then rd_strobe_o, one each, no extra strobes.
- Reset mid-access: assert reset_n_i low during WAIT_RELEASE with CS low → outputs at reset values. After release, one new strobe follows 3 clocks later.
- IRQ: irq_i 0→1→0 → bus_irq_n_o 1→0→1, each change lagging by 1 clock. Reset forces bus_irq_n_o to 1.
- With XOSERA_BUS_TIMEOUT_EN and TIMEOUT_CYC=16, CS held low 40 clocks → timeout_o pulses and a second wr_strobe_o occurs. Without the macro → a single strobe and timeout_o=0.
